// File: rtl/lf_spi_cmd_rx_pkg.sv
// Shared constants for the LF SPI command receiver: command codes, major modes,
// FSM encodings and register reset values.
package lf_spi_cmd_rx_pkg;

  // Command codes carried in bits [15:12] of a frame.
  localparam logic [3:0] FpgaCmdSetConfreg             = 4'd1;
  localparam logic [3:0] FpgaCmdSetDivisor             = 4'd2;
  localparam logic [3:0] FpgaCmdSetEdgeDetectThreshold = 4'd3;

  // Major modes carried in conf_word[8:6].
  localparam logic [2:0] FpgaMajorModeLfReader     = 3'd0;
  localparam logic [2:0] FpgaMajorModeLfEdgeDetect = 3'd1;
  localparam logic [2:0] FpgaMajorModeLfPassthru   = 3'd2;
  localparam logic [2:0] FpgaMajorModeLfAdc        = 3'd3;
  localparam logic [2:0] FpgaMajorModeOff          = 3'd7;

  // Receiver FSM encodings.
  localparam logic [1:0] StWaitIdle = 2'd0;
  localparam logic [1:0] StIdle     = 2'd1;
  localparam logic [1:0] StShift    = 2'd2;
  localparam logic [1:0] StDecode   = 2'd3;

  localparam logic [8:0] ConfWordRst = {FpgaMajorModeOff, 6'b000000};

  localparam logic [4:0] FrameBits  = 5'd16;
  localparam logic [4:0] BitCntMax  = 5'd17;

  typedef struct packed {
    logic [3:0]  code;
    logic [11:0] arg;
  } cmd_t;

  function automatic logic is_edge_detect(input logic [8:0] conf);
    return conf[8:6] == FpgaMajorModeLfEdgeDetect;
  endfunction

endpackage

// File: rtl/lf_spi_cmd_rx_sync_ff.sv
// Multi-stage flop synchroniser with a selectable reset value; Depth must be at least 2.
module lf_spi_cmd_rx_sync_ff #(
  parameter int unsigned Depth  = 2,
  parameter logic        RstVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [Depth-1:0] stages_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages_q <= {Depth{RstVal}};
    end else begin
      stages_q <= {stages_q[Depth-2:0], d};
    end
  end

  assign q = stages_q[Depth-1];

endmodule

// File: rtl/lf_spi_cmd_rx.sv
// Oversampled SPI command receiver: synchronises spck/mosi/ncs into pck0, assembles
// 16-bit frames and decodes them into the LF configuration registers.
module lf_spi_cmd_rx
  import lf_spi_cmd_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DIV_RST     = 8'd95,
  parameter logic [7:0]  THR_RST     = 8'd127
) (
  input  logic       pck0,
  input  logic       nrst,
  input  logic       spck,
  input  logic       mosi,
  input  logic       ncs,
  output logic [8:0] conf_word,
  output logic [7:0] divisor,
  output logic [7:0] lf_ed_threshold,
  output logic       cmd_valid,
  output logic [3:0] cmd_code,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  localparam int unsigned WaitW = $clog2(SYNC_STAGES + 1);
  localparam logic [WaitW-1:0] WaitDone = WaitW'(SYNC_STAGES);

  logic spck_s, mosi_s, ncs_s;
  logic spck_prev_q, ncs_prev_q;
  logic spck_rise, ncs_rise, ncs_fall;

  lf_spi_cmd_rx_sync_ff #(
    .Depth  (SYNC_STAGES),
    .RstVal (1'b0)
  ) u_sync_spck (
    .clk   (pck0),
    .rst_n (nrst),
    .d     (spck),
    .q     (spck_s)
  );

  lf_spi_cmd_rx_sync_ff #(
    .Depth  (SYNC_STAGES),
    .RstVal (1'b0)
  ) u_sync_mosi (
    .clk   (pck0),
    .rst_n (nrst),
    .d     (mosi),
    .q     (mosi_s)
  );

  lf_spi_cmd_rx_sync_ff #(
    .Depth  (SYNC_STAGES),
    .RstVal (1'b1)
  ) u_sync_ncs (
    .clk   (pck0),
    .rst_n (nrst),
    .d     (ncs),
    .q     (ncs_s)
  );

  always_ff @(posedge pck0 or negedge nrst) begin
    if (!nrst) begin
      spck_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b0;
    end else begin
      spck_prev_q <= spck_s;
      ncs_prev_q  <= ncs_s;
    end
  end

  assign spck_rise = spck_s & ~spck_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;

  // Frame FSM and shift datapath.
  logic [1:0]       state_q, state_d;
  logic [15:0]      shift_q, shift_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [WaitW-1:0] wait_q, wait_d;

  // The synchroniser holds its reset value until the live pin has propagated, so
  // ncs is not trusted until the chain has been refilled.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    wait_d    = wait_q;
    unique case (state_q)
      StWaitIdle: begin
        if (wait_q != WaitDone) begin
          wait_d = wait_q + 1'b1;
        end else if (ncs_s) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (ncs_fall) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (spck_rise) begin
          shift_d = {shift_q[14:0], mosi_s};
          if (bit_cnt_q != BitCntMax) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        if (ncs_rise) begin
          state_d = StDecode;
        end
      end
      StDecode: state_d = StIdle;
      default:  state_d = StWaitIdle;
    endcase
  end

  always_ff @(posedge pck0 or negedge nrst) begin
    if (!nrst) begin
      state_q   <= StWaitIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      wait_q    <= wait_d;
    end
  end

  // Frame evaluation and configuration registers.
  cmd_t cmd;
  logic frame_ok, frame_bad;
  logic unused_arg_bits;

  assign cmd             = cmd_t'(shift_q);
  assign frame_ok        = (state_q == StDecode) && (bit_cnt_q == FrameBits);
  assign frame_bad       = (state_q == StDecode) && (bit_cnt_q != FrameBits);
  assign unused_arg_bits = ^cmd.arg[11:9];

  logic [8:0] conf_word_q;
  logic [7:0] divisor_q, thr_q, err_cnt_q;
  logic [3:0] cmd_code_q;
  logic       cmd_valid_q, frame_err_q;

  always_ff @(posedge pck0 or negedge nrst) begin
    if (!nrst) begin
      conf_word_q <= ConfWordRst;
      divisor_q   <= DIV_RST;
      thr_q       <= THR_RST;
      cmd_code_q  <= '0;
      err_cnt_q   <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cmd_valid_q <= frame_ok;
      frame_err_q <= frame_bad;
      if (frame_ok) begin
        cmd_code_q <= cmd.code;
        case (cmd.code)
          FpgaCmdSetConfreg: begin
            conf_word_q <= cmd.arg[8:0];
            // Entering edge-detect mode starts from the default threshold.
            if (is_edge_detect(cmd.arg[8:0])) begin
              thr_q <= THR_RST;
            end
          end
          FpgaCmdSetDivisor:             divisor_q <= cmd.arg[7:0];
          FpgaCmdSetEdgeDetectThreshold: thr_q     <= cmd.arg[7:0];
          default: ;
        endcase
      end
      if (frame_bad && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign conf_word       = conf_word_q;
  assign divisor         = divisor_q;
  assign lf_ed_threshold = thr_q;
  assign cmd_code        = cmd_code_q;
  assign err_cnt         = err_cnt_q;
  assign cmd_valid       = cmd_valid_q;
  assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_lf_spi_cmd_rx.sv
// Directed bench for lf_spi_cmd_rx with a scoreboard of expected decode pulses.
module tb_lf_spi_cmd_rx;

  localparam int unsigned SYNC = 2;
  localparam logic [7:0]  DIV  = 8'd95;
  localparam logic [7:0]  THR  = 8'd127;

  logic       pck0, nrst, spck, mosi, ncs;
  logic [8:0] conf_word;
  logic [7:0] divisor, lf_ed_threshold, err_cnt;
  logic       cmd_valid, frame_err;
  logic [3:0] cmd_code;

  lf_spi_cmd_rx #(
    .SYNC_STAGES (SYNC),
    .DIV_RST     (DIV),
    .THR_RST     (THR)
  ) dut (
    .pck0            (pck0),
    .nrst            (nrst),
    .spck            (spck),
    .mosi            (mosi),
    .ncs             (ncs),
    .conf_word       (conf_word),
    .divisor         (divisor),
    .lf_ed_threshold (lf_ed_threshold),
    .cmd_valid       (cmd_valid),
    .cmd_code        (cmd_code),
    .frame_err       (frame_err),
    .err_cnt         (err_cnt)
  );

  initial pck0 = 1'b0;
  always #5 pck0 = ~pck0;

  int cyc = 0;
  always @(posedge pck0) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic       e;
    logic [3:0] code;
    logic [8:0] conf;
    logic [7:0] div;
    logic [7:0] thr;
    logic [7:0] ecnt;
    int         at;
  } exp_t;

  exp_t sb[$];

  logic [8:0] m_conf;
  logic [7:0] m_div, m_thr, m_err;
  logic [3:0] m_code;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_conf = 9'h1C0;
    m_div  = DIV;
    m_thr  = THR;
    m_err  = 8'd0;
    m_code = 4'd0;
  endfunction

  function automatic void model_frame(input logic [31:0] data, input int nbits, input int rise);
    exp_t e;
    if (nbits == 16) begin
      m_code = data[15:12];
      case (m_code)
        4'd1: begin
          m_conf = data[8:0];
          if (data[8:6] == 3'b001) m_thr = THR;
        end
        4'd2: m_div = data[7:0];
        4'd3: m_thr = data[7:0];
        default: ;
      endcase
      e.v = 1'b1;
      e.e = 1'b0;
    end else begin
      if (m_err != 8'd255) m_err = m_err + 8'd1;
      e.v = 1'b0;
      e.e = 1'b1;
    end
    e.code = m_code;
    e.conf = m_conf;
    e.div  = m_div;
    e.thr  = m_thr;
    e.ecnt = m_err;
    e.at   = rise + SYNC + 2;
    sb.push_back(e);
  endfunction

  // Every pulse must match the oldest outstanding expectation, on the exact cycle.
  always @(negedge pck0) begin
    if (nrst && (cmd_valid || frame_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, cmd_valid, frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_valid", cmd_valid, e.v);
        check("pulse_err", frame_err, e.e);
        check("pulse_code", cmd_code, e.code);
        check("pulse_conf", conf_word, e.conf);
        check("pulse_div", divisor, e.div);
        check("pulse_thr", lf_ed_threshold, e.thr);
        check("pulse_errcnt", err_cnt, e.ecnt);
        check("pulse_cycle", cyc, e.at);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pck0);
    #1;
  endtask

  task automatic drive_bits(input logic [31:0] data, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = data[nbits-1-i];
      spck = 1'b0;
      tick(6);
      spck = 1'b1;
      tick(6);
    end
    spck = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] data, input int nbits);
    ncs = 1'b0;
    tick(4);
    drive_bits(data, nbits);
    tick(4);
    ncs = 1'b1;
    model_frame(data, nbits, cyc);
    tick(10);
    check("pending", sb.size(), 32'd0);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_conf"}, conf_word, m_conf);
    check({tag, "_div"}, divisor, m_div);
    check({tag, "_thr"}, lf_ed_threshold, m_thr);
    check({tag, "_errcnt"}, err_cnt, m_err);
    check({tag, "_code"}, cmd_code, m_code);
    check({tag, "_pulses"}, {30'd0, cmd_valid, frame_err}, 32'd0);
  endtask

  initial begin
    nrst = 1'b0;
    spck = 1'b0;
    mosi = 1'b0;
    ncs  = 1'b1;
    model_reset();
    tick(3);
    check_state("reset");
    nrst = 1'b1;
    tick(10);
    check_state("post_reset");

    send_frame(32'h2058, 16);
    check_state("div_58");

    send_frame(32'h3030, 16);
    check_state("thr_30");
    send_frame(32'h1040, 16);
    check_state("conf_040");
    send_frame(32'h3030, 16);
    send_frame(32'h1000, 16);
    check_state("conf_000");

    send_frame(32'h2011, 15);
    send_frame(32'h12058, 17);
    check_state("bad_len");

    send_frame(32'h7ABC, 16);
    check_state("code_7");

    for (int i = 0; i < 300; i++) begin
      send_frame(32'h1, 1);
    end
    check_state("err_sat");

    // Reset mid-frame: the remainder of that frame must be ignored.
    ncs = 1'b0;
    tick(4);
    drive_bits(32'h20, 8);
    nrst = 1'b0;
    model_reset();
    #2;
    check_state("async_reset");
    tick(3);
    nrst = 1'b1;
    drive_bits(32'h77, 8);
    tick(4);
    ncs = 1'b1;
    tick(12);
    check("ignored_pending", sb.size(), 32'd0);
    check_state("ignored_frame");

    send_frame(32'h2010, 16);
    check_state("div_10");

    tick(10);
    check("final_pending", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lf_spi_cmd_rx.md
# lf_spi_cmd_rx

Oversampled SPI command receiver for the LF FPGA image. It samples the ARM's `spck`/`mosi`/`ncs` lines in the `pck0` domain and assembles 16-bit command words. It decodes them into the configuration registers (`conf_word`, `divisor`, `lf_ed_threshold`) that drive the clock divider, the mode modules and the major-mode output muxes. It replaces the unsynchronised `posedge ncs`/`posedge spck` capture and adds frame-length checking.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth for `spck`, `mosi` and `ncs`; minimum 2.
- `DIV_RST`, default 95: reset value of `divisor` (125 kHz from 12 MHz).
- `THR_RST`, default 127: reset and default value of `lf_ed_threshold`.

Ports (one clock; reset is asynchronous and active-low):
- `pck0`  in  1  system clock, 24 MHz; all logic on its rising edge.
- `nrst`  in  1  asynchronous active-low reset.
- `spck`  in  1  SPI clock from ARM; asynchronous to `pck0`.
- `mosi`  in  1  SPI data; MSB first; valid on `spck` rise.
- `ncs`  in  1  SPI chip select, active-low.
- `conf_word`  out  9  `[8:6]` major mode, `[1]` toggle mode, `[0]` reader field.
- `divisor`  out  8  clock divider setting.
- `lf_ed_threshold`  out  8  edge-detect threshold.
- `cmd_valid`  out  1  one-cycle pulse per well-formed frame.
- `cmd_code`  out  4  bits `[15:12]` of the last well-formed frame.
- `frame_err`  out  1  one-cycle pulse per malformed frame.
- `err_cnt`  out  8  count of malformed frames; saturates at 255.

## Operation
- Each of `spck`, `mosi` and `ncs` passes through `SYNC_STAGES` flops, then one edge-detect flop. `ncs` synchroniser flops reset to 1; all others reset to 0.
- FSM states:
  - WAIT_IDLE (reset state): go to IDLE once synced `ncs` = 1. A frame already in progress when reset releases is ignored.
  - IDLE: a falling edge of synced `ncs` clears `bit_cnt` and `shift` and moves to SHIFT.
  - SHIFT: each synced `spck` rising edge shifts synced `mosi` into `shift[0]` and increments `bit_cnt` (5-bit, saturates at 17). A synced `ncs` rising edge moves to DECODE.
  - DECODE (1 cycle): evaluate the frame, then return to IDLE.
- Frame evaluation in DECODE:
  - `bit_cnt` == 16: pulse `cmd_valid`, load `cmd_code` = `shift[15:12]`, then decode the command:
    - code 1: `conf_word` <= `shift[8:0]`. If `shift[8:6]` == 3'b001, also `lf_ed_threshold` <= `THR_RST`.
    - code 2: `divisor` <= `shift[7:0]`.
    - code 3: `lf_ed_threshold` <= `shift[7:0]`.
    - codes 0 and 4–15: `cmd_valid` still pulses; no register changes.
  - `bit_cnt` != 16 (fewer, or more than 16 via the 17 saturation): pulse `frame_err`, increment `err_cnt` unless it is 255. No register, `cmd_code` or `cmd_valid` change.
- `spck` edges seen while not in SHIFT are ignored.
- An `spck` rise and an `ncs` rise detected in the same cycle: the bit is shifted and counted first, then the FSM enters DECODE.

## Timing
- Reset values:
  - `conf_word` = 9'h1C0 (mode 111, OFF).
  - `divisor` = `DIV_RST`.
  - `lf_ed_threshold` = `THR_RST`.
  - `cmd_code` = 0, `err_cnt` = 0, `cmd_valid` = 0, `frame_err` = 0.
- Input-to-detect latency: `SYNC_STAGES` + 1 cycles.
- Registers, `cmd_valid` and `frame_err` update on the clock edge ending DECODE: `SYNC_STAGES` + 2 cycles after the raw `ncs` rise.
- All outputs are registered and change simultaneously.
- ARM constraints:
  - `spck` high and low time ≥ 3 `pck0` periods (`spck` ≤ 4 MHz).
  - `mosi` stable ≥ 3 periods around each `spck` rise.
  - `ncs` rise ≥ 3 periods after the last `spck` rise.
  - `ncs` high ≥ 4 periods between frames.
- `nrst` asserted at any point aborts the frame and restores all reset values immediately (asynchronously).

## Structure
- Shared header `fpga_lf_defs.v` holds:
  - the command codes (`FPGA_CMD_SET_CONFREG`, `FPGA_CMD_SET_DIVISOR`, `FPGA_CMD_SET_EDGE_DETECT_THRESHOLD`);
  - the major-mode codes;
  - the FSM state encodings;
  - the `conf_word` reset constant.
  It is included by both this block and `fpga_lf`.
- One sub-module, `sync_ff` (parameterised depth, reset value parameter), instantiated three times.

## Test plan
- Reset → `conf_word` 0x1C0, `divisor` 95, threshold 127, `err_cnt` 0; no pulses.
- Frame 0x2058 at 2 MHz `spck` → `divisor` 0x58, `cmd_code` 2, one `cmd_valid` pulse exactly `SYNC_STAGES`+2 cycles after `ncs` rise.
- Frame 0x3030, then 0x1040 → threshold 0x30 after the first frame, then `conf_word` 0x040 with threshold back to 127. Repeat with 0x1000 → threshold stays 0x30.
- 15-bit frame and 17-bit frame → two `frame_err` pulses, `err_cnt` 2, all config unchanged. 300 bad frames → `err_cnt` holds 255.
- Frame 0x7ABC → `cmd_valid` with `cmd_code` 7; config unchanged.
- `nrst` pulsed after 8 bits of a frame, with `ncs` still low at release → defaults restored, rest of that frame ignored (no pulses). Next 0x2010 frame → `divisor` 0x10.
